// File: rtl/data_mem_bytelane.sv
// Single-port data memory with byte-lane stores, sized sign/zero-extended loads,
// a post-reset/clear zeroing sweep and error responses for misaligned accesses.
module data_mem_bytelane #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128,
    localparam int OFF_W  = $clog2(DATA_W / 8),
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int ADDR_W = IDX_W + OFF_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_misaligned,
    output logic              init_busy
);

    localparam int unsigned BYTES = DATA_W / 8;

    typedef enum logic {INIT, RUN} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_mis_q, rsp_mis_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              accept;
    logic              legal;
    logic              sign;
    logic [IDX_W-1:0]  idx;
    int unsigned       off_n;
    int unsigned       nbytes;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] wdata_sh;
    logic [BYTES-1:0]  be;

    assign idx       = req_addr[ADDR_W-1:OFF_W];
    assign req_ready = (state_q == RUN) && !clear;
    assign accept    = req_valid && req_ready;
    assign init_busy = (state_q == INIT);

    // Lane mask and sign position are derived from the access size, so one
    // path covers every legal size including the full-width (no-extend) case.
    always_comb begin
        off_n    = 32'(req_addr[OFF_W-1:0]);
        nbytes   = 32'd1 << req_size;
        legal    = (nbytes <= BYTES) && ((off_n & (nbytes - 1)) == 0);
        word     = mem_q[idx];
        shifted  = word >> (8 * off_n);
        wdata_sh = req_wdata << (8 * off_n);
        mask     = '0;
        sign     = 1'b0;
        be       = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            mask[i] = (i < 8 * nbytes);
            if (i == 8 * nbytes - 1) sign = shifted[i];
        end
        for (int unsigned b = 0; b < BYTES; b++) begin
            be[b] = accept && req_we && legal && (b >= off_n) && (b < off_n + nbytes);
        end
        load_ext = shifted & mask;
        if (!req_unsigned && sign) load_ext = load_ext | ~mask;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_mis_d   = rsp_mis_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == IDX_W'(DEPTH - 1)) state_d = RUN;
            end
            RUN: begin
                if (clear) begin
                    state_d     = INIT;
                    cnt_d       = '0;
                    rsp_rdata_d = '0;
                    rsp_mis_d   = 1'b0;
                end else if (accept && (!legal || !req_we)) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = legal ? load_ext : '0;
                    rsp_mis_d   = !legal;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_mis_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_mis_q   <= rsp_mis_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem_q[cnt_q] <= '0;
        end else begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_misaligned = rsp_mis_q;

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Scoreboard bench for data_mem_bytelane: a byte-array reference model predicts
// responses at issue time; a negedge monitor pops and compares each response.
module tb_data_mem_bytelane;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              reset;
    logic              clear;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_misaligned;
    logic              init_busy;

    typedef struct {
        logic        mis;
        logic [31:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] ref_mem [DEPTH*4];
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    data_mem_bytelane #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_misaligned (rsp_misaligned),
        .init_busy      (init_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    endfunction

    // Drives one request for one cycle; the model decides the outcome from
    // byte-address arithmetic alone.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input int unsigned addr, input logic [31:0] wd);
        int unsigned     nb;
        bit              lg;
        longint unsigned v;
        nb           = 32'd1 << size;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = ADDR_W'(addr);
        req_wdata    = wd;
        @(negedge clk);
        chk("req_ready", 64'(req_ready), 64'd1);
        lg = (nb <= 4) && (addr % nb == 0);
        if (!lg) begin
            sb.push_back('{1'b1, 32'h0});
        end else if (we) begin
            for (int unsigned k = 0; k < nb; k++) ref_mem[addr + k] = 8'(wd >> (8 * k));
        end else begin
            v = 0;
            for (int unsigned k = 0; k < nb; k++) v = v | (64'(ref_mem[addr + k]) << (8 * k));
            if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 1);
            sb.push_back('{1'b0, v[31:0]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_sweep(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk({tag, "_busy"}, 64'(init_busy), 64'd1);
            chk({tag, "_not_ready"}, 64'(req_ready), 64'd0);
            if (i == 0) begin
                chk({tag, "_rsp_valid0"}, 64'(rsp_valid), 64'd0);
                chk({tag, "_rsp_rdata0"}, 64'(rsp_rdata), 64'd0);
                chk({tag, "_rsp_mis0"}, 64'(rsp_misaligned), 64'd0);
            end
        end
        @(negedge clk);
        chk({tag, "_busy_done"}, 64'(init_busy), 64'd0);
        chk({tag, "_ready_up"}, 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_rsp: got rdata %0h mis %0b expected no response at %0t",
                             rsp_rdata, rsp_misaligned, $time);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_misaligned", 64'(rsp_misaligned), 64'(e.mis));
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset        = 1'b1;
        clear        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(init_busy), 64'd1);
        chk("reset_ready", 64'(req_ready), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("reset_rsp_mis", 64'(rsp_misaligned), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_sweep("reset");

        // Directed cases from the byte-lane examples
        issue(1'b0, 2'd2, 1'b0, 32'h1FC, 32'h0);
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000007F);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        issue(1'b1, 2'd1, 1'b0, 32'h11, 32'h0000FFFF);
        issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
        issue(1'b0, 2'd2, 1'b1, 32'h10, 32'h0);
        idle();
        idle();
        @(negedge clk);
        chk("rdata_hold", 64'(rsp_rdata), 64'h00000000DEAD7FEF);
        chk("valid_pulse", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;

        // Randomized mix over a small window so stores and loads collide
        repeat (400) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 63), $urandom);
            if ($urandom_range(0, 3) == 0) idle();
        end

        // Clear while loads stream: the clear-cycle load must not be taken
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h18, 32'h0);
        clear     = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = ADDR_W'(32'h10);
        @(negedge clk);
        chk("ready_in_clear", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        clear     = 1'b0;
        req_valid = 1'b0;
        model_clear();
        check_sweep("clear");
        for (int w = 0; w < DEPTH; w++) issue(1'b0, 2'd2, 1'b0, 32'(w * 4), 32'h0);

        // Reset in the middle of a sweep at counter 50
        repeat (20) issue(1'b1, 2'($urandom_range(0, 2)), 1'b0, 4 * $urandom_range(0, 15), $urandom);
        clear = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        clear = 1'b0;
        model_clear();
        repeat (50) @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("mid_sweep_reset_busy", 64'(init_busy), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_sweep("reset_mid_sweep");

        // Reset while a load response is pending
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h12345678);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        reset     = 1'b1;
        req_valid = 1'b0;
        sb.delete();
        model_clear();
        @(negedge clk);
        chk("rsp_dropped", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_sweep("reset_rsp");
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        repeat (3) idle();
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
